// File: rtl/seg_scan_if.sv
// Bundles the value/control inputs and the digit/segment pin outputs of the
// multiplexed 7-segment scanner.
interface seg_scan_if #(
  parameter int NDIG     = 8,
  parameter int BRIGHT_W = 4
);
  logic [4*NDIG-1:0]   s;
  logic [NDIG-1:0]     dp;
  logic [NDIG-1:0]     blank_mask;
  logic                lz_en;
  logic [BRIGHT_W-1:0] bright;
  logic [7:0]          seg;
  logic [NDIG-1:0]     ans;
  logic                frame_done;

  modport master (
    output s, dp, blank_mask, lz_en, bright,
    input  seg, ans, frame_done
  );

  modport slave (
    input  s, dp, blank_mask, lz_en, bright,
    output seg, ans, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// N-digit time-multiplexed 7-segment scan controller with per-frame input snapshot,
// leading-zero suppression, blank mask, PWM brightness and a dark first cycle per slot.
module seg_scan_ctrl #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 65536,
  parameter int BRIGHT_W = 4
) (
  input logic      clk,
  input logic      reset,
  seg_scan_if.slave bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NDIG);
  localparam int THR_W = DIV_W + BRIGHT_W + 1;

  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  idx;
  logic              last_div;
  logic              frame_edge;

  logic [4*NDIG-1:0] sh_s;
  logic [NDIG-1:0]   sh_dp;
  logic [NDIG-1:0]   sh_blank;
  logic              sh_lz;

  logic [THR_W-1:0]  thr;
  logic [NDIG-1:0]   supp;
  logic              lz_nz;
  logic [3:0]        nib;
  logic              lit;

  logic [7:0]        seg_q;
  logic [NDIG-1:0]   ans_q;
  logic              frame_done_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign last_div   = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_edge = last_div && (idx == IDX_W'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div <= '0;
      idx <= '0;
    end else if (last_div) begin
      div <= '0;
      idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Snapshot on the same edge idx wraps, so a whole frame shows one consistent value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_s     <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
    end else if (frame_edge) begin
      sh_s     <= bus.s;
      sh_dp    <= bus.dp;
      sh_blank <= bus.blank_mask;
      sh_lz    <= bus.lz_en;
    end
  end

  always_comb begin
    thr = ((THR_W'(bus.bright) + THR_W'(1)) * THR_W'(SCAN_DIV)) >> BRIGHT_W;
  end

  // Scan from the top digit down: a digit is suppressed while nothing non-zero is above it.
  always_comb begin
    supp  = '0;
    lz_nz = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_nz   = lz_nz | (sh_s[4*i +: 4] != 4'h0);
      supp[i] = sh_lz & ~lz_nz & (i != 0);
    end
  end

  assign nib = sh_s[{idx, 2'b00} +: 4];
  assign lit = (div != '0) && ({{(THR_W - DIV_W){1'b0}}, div} < thr) && !sh_blank[idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q        <= '0;
      ans_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_edge;
      if (lit) begin
        ans_q <= NDIG'(1) << idx;
        seg_q <= {sh_dp[idx], supp[idx] ? 7'h00 : hex7(nib)};
      end else begin
        ans_q <= '0;
        seg_q <= '0;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.ans        = ans_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 16 cycles per slot, 2-bit brightness):
// directed scenarios with fixed expectations plus randomized traffic against a frame-position model.
module tb_seg_scan_ctrl;
  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 16;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = NDIG * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_if #(.NDIG(NDIG), .BRIGHT_W(BRIGHT_W)) bus ();

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] hex_tab [16];

  // Reference model: position within the frame, the frame snapshot, and expected pins.
  int         m_pos;
  logic [15:0] m_sh_s;
  logic [3:0] m_sh_dp, m_sh_bl;
  logic       m_sh_lz;
  logic [7:0] m_seg;
  logic [3:0] m_ans;
  logic       m_fd;

  always @(posedge clk) begin : model
    int  d, i, thr;
    bit  lit, supp;
    logic [3:0] nib;
    if (!reset) begin
      m_pos = 0; m_sh_s = '0; m_sh_dp = '0; m_sh_bl = '0; m_sh_lz = 1'b0;
      m_seg = '0; m_ans = '0; m_fd = 1'b0;
    end else begin
      d    = m_pos % SCAN_DIV;
      i    = m_pos / SCAN_DIV;
      thr  = (int'(bus.bright) + 1) * SCAN_DIV / (1 << BRIGHT_W);
      nib  = 4'(m_sh_s >> (4 * i));
      supp = m_sh_lz && (i > 0) && ((m_sh_s >> (4 * i)) == 16'h0);
      lit  = (d != 0) && (d < thr) && !m_sh_bl[i];
      m_ans = lit ? 4'(1 << i) : 4'h0;
      m_seg = lit ? {m_sh_dp[i], supp ? 7'h00 : hex_tab[nib]} : 8'h00;
      m_fd  = (m_pos == FRAME - 1);
      if (m_pos == FRAME - 1) begin
        m_sh_s = bus.s; m_sh_dp = bus.dp; m_sh_bl = bus.blank_mask; m_sh_lz = bus.lz_en;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_inputs(input logic [15:0] s, input logic [3:0] dp, input logic [3:0] bl,
                            input logic lz, input logic [1:0] br);
    bus.s = s; bus.dp = dp; bus.blank_mask = bl; bus.lz_en = lz; bus.bright = br;
  endtask

  task automatic test_reset();
    int cnt;
    logic [7:0] es;
    logic [3:0] ea;
    set_inputs(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    repeat (21) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg !== 8'h00 || bus.ans !== 4'h0 || bus.frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold: seg=%h ans=%b fd=%b, want 00 0000 0", bus.seg, bus.ans, bus.frame_done);
      end
    end
    reset = 1'b1;
    // First frame after release shows the zeroed snapshot: every digit "0".
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      es = (((k - 1) % SCAN_DIV) != 0) ? 8'h3F : 8'h00;
      ea = (((k - 1) % SCAN_DIV) != 0) ? 4'(1 << ((k - 1) / SCAN_DIV)) : 4'h0;
      tests_run++;
      if (bus.seg !== es || bus.ans !== ea || bus.frame_done !== (k == FRAME)) begin
        tests_failed++;
        $display("FAIL first_frame k=%0d: seg=%h ans=%b fd=%b, want %h %b %b",
                 k, bus.seg, bus.ans, bus.frame_done, es, ea, (k == FRAME));
      end
    end
    cnt = 0;
    for (int k = 1; k <= 4 * FRAME; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        cnt = k;
        break;
      end
    end
    tests_run++;
    if (cnt != FRAME) begin
      tests_failed++;
      $display("FAIL frame_period: got %0d cycles, want %0d", cnt, FRAME);
    end
  endtask

  task automatic test_hex();
    bit ok;
    logic [7:0] dig [4];
    logic [7:0] es;
    logic [3:0] ea;
    int i, d;
    dig = '{8'h71, 8'h77, 8'h5B, 8'h06};
    set_inputs(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    wait_frame(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL hex_wait: frame_done=0, want 1"); end
    for (int p = 0; p < FRAME; p++) begin
      @(negedge clk);
      i = p / SCAN_DIV; d = p % SCAN_DIV;
      es = (d != 0) ? dig[i] : 8'h00;
      ea = (d != 0) ? 4'(1 << i) : 4'h0;
      tests_run++;
      if (bus.seg !== es || bus.ans !== ea) begin
        tests_failed++;
        $display("FAIL hex p=%0d: seg=%h ans=%b, want %h %b", p, bus.seg, bus.ans, es, ea);
      end
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [7:0] es;
    set_inputs(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
    wait_frame(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL snap_wait: frame_done=0, want 1"); end
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        es = ((p % SCAN_DIV) != 0) ? ((f == 0) ? 8'h06 : 8'h5B) : 8'h00;
        tests_run++;
        if (bus.seg !== es || bus.frame_done !== (p == FRAME - 1)) begin
          tests_failed++;
          $display("FAIL snapshot f=%0d p=%0d: seg=%h fd=%b, want %h %b",
                   f, p, bus.seg, bus.frame_done, es, (p == FRAME - 1));
        end
        if (f == 0 && p == 20) bus.s = 16'h2222;
      end
    end
  endtask

  task automatic test_lz();
    bit ok;
    logic [7:0] dig [4];
    logic [7:0] es;
    logic [3:0] ea;
    int i, d;
    set_inputs(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3);
    for (int c = 0; c < 2; c++) begin
      if (c == 1) bus.s = 16'h0000;
      dig = (c == 0) ? '{8'h3F, 8'h6D, 8'h00, 8'h00} : '{8'h3F, 8'h00, 8'h00, 8'h00};
      wait_frame(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL lz_wait: frame_done=0, want 1"); end
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        i = p / SCAN_DIV; d = p % SCAN_DIV;
        es = (d != 0) ? dig[i] : 8'h00;
        ea = (d != 0) ? 4'(1 << i) : 4'h0;
        tests_run++;
        if (bus.seg !== es || bus.ans !== ea) begin
          tests_failed++;
          $display("FAIL lz c=%0d p=%0d: seg=%h ans=%b, want %h %b", c, p, bus.seg, bus.ans, es, ea);
        end
      end
    end
  endtask

  task automatic test_bright();
    bit ok;
    int on_cnt, d, thr, want;
    set_inputs(16'h8421, 4'h0, 4'h0, 1'b0, 2'd1);
    wait_frame(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bright_wait: frame_done=0, want 1"); end
    for (int b = 1; b >= 0; b--) begin
      bus.bright = 2'(b);
      thr  = (b == 1) ? 8 : 4;
      want = thr - 1;
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        d = p % SCAN_DIV;
        if (d == 0) on_cnt = 0;
        if (bus.ans !== 4'h0) on_cnt++;
        tests_run++;
        if ((bus.ans !== 4'h0) !== (d >= 1 && d < thr)) begin
          tests_failed++;
          $display("FAIL bright b=%0d p=%0d: ans=%b, want lit=%0d", b, p, bus.ans, (d >= 1 && d < thr));
        end
        if (d == SCAN_DIV - 1) begin
          tests_run++;
          if (on_cnt != want) begin
            tests_failed++;
            $display("FAIL bright_count b=%0d slot=%0d: got %0d, want %0d", b, p / SCAN_DIV, on_cnt, want);
          end
        end
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    logic [7:0] es;
    logic [3:0] ea;
    int i, d;
    set_inputs(16'h8888, 4'b0101, 4'b0100, 1'b0, 2'd3);
    wait_frame(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL blank_wait: frame_done=0, want 1"); end
    for (int p = 0; p < FRAME; p++) begin
      @(negedge clk);
      i = p / SCAN_DIV; d = p % SCAN_DIV;
      if (i == 2 || d == 0) begin
        es = 8'h00; ea = 4'h0;
      end else begin
        es = (i == 0) ? 8'hFF : 8'h7F;
        ea = 4'(1 << i);
      end
      tests_run++;
      if (bus.seg !== es || bus.ans !== ea) begin
        tests_failed++;
        $display("FAIL blank p=%0d: seg=%h ans=%b, want %h %b", p, bus.seg, bus.ans, es, ea);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      set_inputs(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 1'($urandom), 2'($urandom));
      if (f[0]) bus.s = bus.s & 16'h00FF;
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        tests_run++;
        if (bus.seg !== m_seg || bus.ans !== m_ans || bus.frame_done !== m_fd) begin
          tests_failed++;
          $display("FAIL random f=%0d p=%0d: seg=%h ans=%b fd=%b, want %h %b %b",
                   f, p, bus.seg, bus.ans, bus.frame_done, m_seg, m_ans, m_fd);
        end
        reset = !(f == 5 && p == 30);
        if ($urandom_range(0, 19) == 0) bus.s = 16'($urandom);
        if ($urandom_range(0, 9) == 0) bus.bright = 2'($urandom);
        if ($urandom_range(0, 19) == 0) bus.lz_en = 1'($urandom);
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset = 1'b0;
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0, 2'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_hex();
    test_snapshot();
    test_lz();
    test_bright();
    test_blank();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
